dcache_wb_fifo: RTL

- Parametrised set-associative, write-back, write-allocate data cache with FIFO replacement per set.
- Sits between the CPU memory stage (simple request/valid slave port) and the AXI master bridge (burst read refill, burst write-back).
- Successor of the fixed 4-set/4-way read-only FIFO cache. Adds store hits with byte strobes, dirty tracking, victim write-back and a configurable geometry.

---
 rtl/dcache_pkg.sv | 39 +++
 rtl/dcache_way_store.sv | 59 +++++
 rtl/dcache_wb_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, burst constants and width helpers for the write-back data cache
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT_RSP,
        ST_WB_AW,
        ST_WB_W,
        ST_WB_B,
        ST_RF_AR,
        ST_RF_R,
        ST_MISS_RSP
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] BURST_SIZE_4B = 3'b010;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

    function automatic int idx_w(input int sets);
        return clog2(sets);
    endfunction

    function automatic int off_w(input int line_words);
        return clog2(line_words) + 2;
    endfunction

    function automatic int tag_w(input int sets, input int line_words);
        return 32 - idx_w(sets) - off_w(line_words);
    endfunction

endpackage

// File: rtl/dcache_way_store.sv
// rtl/dcache_way_store.sv - one cache way: tag/valid/dirty per set and a word-addressed data array
module dcache_way_store
    import dcache_pkg::*;
#(
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 16,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = clog2(SETS),
    parameter int WORD_W     = clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_set,
    input  logic [WORD_W-1:0] i_rd_word,
    output logic [31:0]       o_rd_data,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid,
    output logic              o_dirty,
    input  logic              i_wr_en,
    input  logic [WORD_W-1:0] i_wr_word,
    input  logic [31:0]       i_wr_data,
    input  logic [3:0]        i_wr_strb,
    input  logic              i_meta_we,
    input  logic [TAG_W-1:0]  i_meta_tag,
    input  logic              i_meta_valid,
    input  logic              i_meta_dirty
);

    logic [31:0]      r_data [SETS*LINE_WORDS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;

    assign o_rd_data = r_data[{i_set, i_rd_word}];
    assign o_tag     = r_tag[i_set];
    assign o_valid   = r_valid[i_set];
    assign o_dirty   = r_dirty[i_set];

    // Data and tags need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_strb[b]) r_data[{i_set, i_wr_word}][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
        if (i_meta_we) r_tag[i_set] <= i_meta_tag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_meta_we) begin
            r_valid[i_set] <= i_meta_valid;
            r_dirty[i_set] <= i_meta_dirty;
        end
    end

endmodule

// File: rtl/dcache_wb_fifo.sv
// rtl/dcache_wb_fifo.sv - set-associative write-back/write-allocate data cache, FIFO replacement per set
module dcache_wb_fifo
    import dcache_pkg::*;
#(
    parameter int SETS       = 4,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_addr,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic        s_rvalid,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wvalid,
    output logic        s_wready,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready
);

    localparam int IDX = idx_w(SETS);
    localparam int OFF = off_w(LINE_WORDS);
    localparam int TAG = tag_w(SETS, LINE_WORDS);
    localparam int BW  = OFF - 2;
    localparam int WW  = clog2(WAYS);
    localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

    state_t            r_state, w_next;
    logic [31:0]       r_addr, r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_is_store;
    logic [WW-1:0]     r_way;
    logic [BW-1:0]     r_beat;
    logic [WW-1:0]     r_fifo_ptr [SETS];

    logic [31:0]       w_lookup_addr;
    logic [IDX-1:0]    w_set;
    logic [BW-1:0]     w_rd_word_idx, w_wr_word_idx;
    logic [TAG-1:0]    w_tag [WAYS];
    logic [31:0]       w_rd_word [WAYS];
    logic [WAYS-1:0]   w_valid, w_dirty, w_hit, w_word_we, w_meta_we;
    logic [WW-1:0]     w_hit_way, w_victim;
    logic              w_any_hit, w_req, w_rsp_store, w_last_beat;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_wr_strb;
    logic [TAG-1:0]    w_meta_tag;
    logic              w_unused_addr_lsb;

    // The lookup follows the live request in IDLE and the latched request everywhere else.
    assign w_lookup_addr = (r_state == ST_IDLE) ? s_addr : r_addr;
    assign w_set         = w_lookup_addr[OFF+IDX-1:OFF];
    assign w_rd_word_idx = (r_state == ST_WB_W) ? r_beat : r_addr[OFF-1:2];
    assign w_wr_word_idx = (r_state == ST_RF_R) ? r_beat : r_addr[OFF-1:2];
    assign w_wr_data     = (r_state == ST_RF_R) ? m_rdata : r_wdata;
    assign w_wr_strb     = (r_state == ST_RF_R) ? 4'hf : r_wstrb;
    assign w_meta_tag    = (r_state == ST_RF_R) ? r_addr[31:OFF+IDX] : w_tag[r_way];
    assign w_rsp_store   = ((r_state == ST_HIT_RSP) || (r_state == ST_MISS_RSP)) && r_is_store;
    assign w_req         = s_rready || (s_wvalid != 4'h0);
    assign w_any_hit     = |w_hit;
    assign w_victim      = r_fifo_ptr[w_set];
    assign w_last_beat   = (r_beat == BW'(LINE_WORDS - 1));
    assign w_unused_addr_lsb = ^r_addr[1:0];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        dcache_way_store #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG)
        ) u_way (
            .clk          (clk),
            .rst          (rst),
            .i_set        (w_set),
            .i_rd_word    (w_rd_word_idx),
            .o_rd_data    (w_rd_word[g]),
            .o_tag        (w_tag[g]),
            .o_valid      (w_valid[g]),
            .o_dirty      (w_dirty[g]),
            .i_wr_en      (w_word_we[g]),
            .i_wr_word    (w_wr_word_idx),
            .i_wr_data    (w_wr_data),
            .i_wr_strb    (w_wr_strb),
            .i_meta_we    (w_meta_we[g]),
            .i_meta_tag   (w_meta_tag),
            .i_meta_valid (1'b1),
            .i_meta_dirty (w_rsp_store)
        );
        assign w_hit[g] = w_valid[g] && (w_tag[g] == w_lookup_addr[31:OFF+IDX]);
    end

    always_comb begin
        w_hit_way = '0;
        w_word_we = '0;
        w_meta_we = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_hit[i]) w_hit_way = WW'(i);
        end
        if (((r_state == ST_RF_R) && m_rvalid) || w_rsp_store) w_word_we[r_way] = 1'b1;
        if (((r_state == ST_RF_R) && m_rvalid && m_rlast) ||
            ((r_state == ST_WB_B) && m_bvalid) || w_rsp_store) w_meta_we[r_way] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        s_rdata   = '0;
        s_rvalid  = 1'b0;
        s_wready  = 1'b0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_any_hit)                             w_next = ST_HIT_RSP;
                    else if (w_valid[w_victim] && w_dirty[w_victim]) w_next = ST_WB_AW;
                    else                                       w_next = ST_RF_AR;
                end
            end
            ST_HIT_RSP, ST_MISS_RSP: begin
                s_rvalid = !r_is_store;
                s_wready = r_is_store;
                s_rdata  = r_is_store ? 32'h0 : w_rd_word[r_way];
                w_next   = ST_IDLE;
            end
            ST_WB_AW: begin
                m_awvalid = 1'b1;
                m_awaddr  = {w_tag[r_way], r_addr[OFF+IDX-1:OFF], {OFF{1'b0}}};
                m_awlen   = BURST_LEN;
                if (m_awready) w_next = ST_WB_W;
            end
            ST_WB_W: begin
                m_wvalid = 1'b1;
                m_wstrb  = 4'hf;
                m_wdata  = w_rd_word[r_way];
                m_wlast  = w_last_beat;
                if (m_wready && w_last_beat) w_next = ST_WB_B;
            end
            ST_WB_B: begin
                m_bready = 1'b1;
                if (m_bvalid) w_next = ST_RF_AR;
            end
            ST_RF_AR: begin
                m_arvalid = 1'b1;
                m_araddr  = {r_addr[31:OFF], {OFF{1'b0}}};
                m_arlen   = BURST_LEN;
                if (m_arready) w_next = ST_RF_R;
            end
            ST_RF_R: begin
                m_rready = 1'b1;
                if (m_rvalid && m_rlast) w_next = ST_MISS_RSP;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A simultaneous read and store latches the read; the held store is taken on a later IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_is_store <= 1'b0;
            r_way      <= '0;
            r_beat     <= '0;
            for (int i = 0; i < SETS; i++) r_fifo_ptr[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr     <= s_addr;
                        r_wdata    <= s_wdata;
                        r_wstrb    <= s_wvalid;
                        r_is_store <= !s_rready;
                        r_way      <= w_any_hit ? w_hit_way : w_victim;
                    end
                end
                ST_WB_AW, ST_RF_AR: r_beat <= '0;
                ST_WB_W: if (m_wready) r_beat <= r_beat + 1'b1;
                ST_RF_R: begin
                    if (m_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (m_rlast) r_fifo_ptr[w_set] <= r_fifo_ptr[w_set] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
